// File: rtl/vae_pkg.sv
// vae_pkg: datapath sizes shared by the reduction tree and the lane gather front end.
`default_nettype none

package vae_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int TREE_LANES = 8;
  localparam int LANE_IDX_W = $clog2(TREE_LANES);
  localparam int LANE_CNT_W = $clog2(TREE_LANES + 1);

  typedef logic [DATA_WIDTH-1:0] lane_t;
  typedef logic [LANE_IDX_W-1:0] lane_idx_t;
  typedef logic [LANE_CNT_W-1:0] lane_cnt_t;

endpackage

`default_nettype wire

// File: rtl/lane_gather.sv
// lane_gather: packs a valid/ready word stream into LANES-wide zero-padded vectors for the tree adder.
// Revision 1.0
`default_nettype none

module lane_gather
  import vae_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int LANES = TREE_LANES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             s_data,
  input  logic                         s_valid,
  input  logic                         s_last,
  output logic                         s_ready,
  output logic [LANES*WIDTH-1:0]       m_data,
  output logic [$clog2(LANES+1)-1:0]   m_count,
  output logic                         m_last,
  output logic                         m_valid,
  input  logic                         m_ready
);

  localparam int IW = $clog2(LANES);
  localparam int CW = $clog2(LANES + 1);

  logic [LANES*WIDTH-1:0] fbuf_q, fbuf_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   fdone_q, fdone_d;
  logic [CW-1:0]          fcnt_q, fcnt_d;
  logic                   flast_q, flast_d;

  logic [LANES*WIDTH-1:0] obuf_q;
  logic [CW-1:0]          ocnt_q;
  logic                   olast_q;
  logic                   ovalid_q;

  logic          w_accept;
  logic          w_xfer;
  logic [IW-1:0] w_lane;

  assign w_xfer   = fdone_q & (~ovalid_q | m_ready);
  // Ready comes only from registered state and m_ready, never from s_valid.
  assign s_ready  = ~fdone_q | w_xfer;
  assign w_accept = s_valid & s_ready;
  assign w_lane   = w_xfer ? '0 : idx_q;

  always_comb begin
    fbuf_d  = fbuf_q;
    idx_d   = idx_q;
    fdone_d = fdone_q;
    fcnt_d  = fcnt_q;
    flast_d = flast_q;
    if (w_xfer) begin
      fbuf_d  = '0;
      idx_d   = '0;
      fdone_d = 1'b0;
    end
    // A word accepted alongside a transfer lands in the freshly cleared lane 0.
    if (w_accept) begin
      fbuf_d[w_lane*WIDTH +: WIDTH] = s_data;
      if (s_last || (w_lane == IW'(LANES - 1))) begin
        fdone_d = 1'b1;
        fcnt_d  = CW'(w_lane) + CW'(1);
        flast_d = s_last;
      end else begin
        idx_d = w_lane + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fbuf_q  <= '0;
      idx_q   <= '0;
      fdone_q <= 1'b0;
      fcnt_q  <= '0;
      flast_q <= 1'b0;
    end else begin
      fbuf_q  <= fbuf_d;
      idx_q   <= idx_d;
      fdone_q <= fdone_d;
      fcnt_q  <= fcnt_d;
      flast_q <= flast_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      obuf_q   <= '0;
      ocnt_q   <= '0;
      olast_q  <= 1'b0;
      ovalid_q <= 1'b0;
    end else if (w_xfer) begin
      obuf_q   <= fbuf_q;
      ocnt_q   <= fcnt_q;
      olast_q  <= flast_q;
      ovalid_q <= 1'b1;
    end else if (ovalid_q && m_ready) begin
      ovalid_q <= 1'b0;
    end
  end

  assign m_data  = obuf_q;
  assign m_count = ocnt_q;
  assign m_last  = olast_q;
  assign m_valid = ovalid_q;

endmodule

`default_nettype wire
